// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,   // partial product high / remainder
    input  logic [WIDTH-1:0] acc_lo,   // multiplier bits / dividend-quotient
    input  logic [WIDTH-1:0] opnd,     // multiplicand / divisor
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // Multiply consumes the LSB of acc_lo and shifts right; divide shifts left
    // and commits the trial subtraction when the divisor fits.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = fits ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div, neg_q, neg_r, dbz_pend;
    logic               busy_q, done_q, dbz_q;

    logic               is_arith, is_signed, op_div, dz_c, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Operand decode, magnitudes and final sign correction.
    always_comb begin
        is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        dz_c      = op_div && (b == '0);
        sign_a    = is_signed && a[WIDTH-1];
        sign_b    = is_signed && b[WIDTH-1];
        abs_a     = sign_a ? (~a + WIDTH'(1)) : a;
        abs_b     = sign_b ? (~b + WIDTH'(1)) : b;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix   = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_fix   = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end

    // Next-state logic; abort always wins back to IDLE.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start && is_arith) state_d = dz_c ? S_FINISH : S_CALC;
            S_CALC:   if (abort) state_d = S_IDLE;
                      else if (cnt == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    // Datapath, counter, HI/LO and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d != S_IDLE);
            case (state)
                S_IDLE: if (start) begin
                    if (is_arith) begin
                        acc_hi   <= '0;
                        acc_lo   <= dz_c ? a : (op_div ? abs_a : abs_b);
                        opnd     <= op_div ? abs_b : abs_a;
                        is_div   <= op_div;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        dbz_pend <= dz_c;
                        cnt      <= '0;
                        dbz_q    <= 1'b0;
                    end else if (op == OP_MTHI) begin
                        hi_q <= a;
                    end else if (op == OP_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_CALC: if (!abort) begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_FINISH: if (!abort) begin
                    done_q <= 1'b1;
                    if (dbz_pend) begin
                        hi_q  <= acc_lo;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): vector table, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        abort;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vt[8];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op computed with plain wide arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; {m_hi, m_lo} = p; m_dz = 1'b0; end
            3'd1: begin up = 64'(x) * 64'(y); {m_hi, m_lo} = up; m_dz = 1'b0; end
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    m_hi = x; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1;
                end else if (o == 3'd2) begin
                    m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); m_dz = 1'b0;
                end else begin
                    m_lo = x / y; m_hi = x % y; m_dz = 1'b0;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Launch an op (sampled at the next edge) and wait, bounded, for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
        int lat;
        int exp_lat;
        model_apply(o, x, y);
        exp_lat = (o[1] && y == 32'd0) ? 1 : 33;
        run_op(o, x, y, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(m_dz));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 15));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat;
        int seen;
        logic [31:0] x, y;
        logic [2:0]  o;

        vt[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vt[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
        vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vt[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vt[4] = '{3'd3, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, 1};
        vt[5] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33};
        vt[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vt[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};

        reset = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; a = '0; b = '0;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        #20 reset = 1'b1;
        @(posedge clk); #1;

        // Cycle-exact latency and busy profile for a full-width multiply
        op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk); #1;
            chk($sformatf("profile busy c%0d", i), 32'(busy), 32'(i <= 32));
            chk($sformatf("profile done c%0d", i), 32'(done), 32'(i == 33));
        end
        chk("profile hi", hi, 32'hFFFF_FFFE);
        chk("profile lo", lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("done pulse width", 32'(done), 32'd0);

        // Vector table, issued back-to-back: each start lands in the previous done cycle
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d hi", i), hi, vt[i].hi);
            chk($sformatf("vec%0d lo", i), lo, vt[i].lo);
            chk($sformatf("vec%0d dbz", i), 32'(div_by_zero), 32'(vt[i].dz));
        end
        @(posedge clk); #1;

        // MTHI then MTLO: single-edge update, never busy or done
        op = 3'd4; a = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi busy", 32'(busy), 32'd0);
        chk("mthi done", 32'(done), 32'd0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo lo", lo, 32'h9ABC_DEF0);
        chk("mtlo hi kept", hi, 32'h1234_5678);
        chk("mtlo busy", 32'(busy), 32'd0);
        chk("mtlo done", 32'(done), 32'd0);

        // Reserved opcodes have no effect
        op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rsvd hi", hi, 32'h1234_5678);
        chk("rsvd lo", lo, 32'h9ABC_DEF0);
        chk("rsvd busy", 32'(busy), 32'd0);

        // Start while busy is ignored
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin @(posedge clk); #1; end
        op = 3'd1; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 7; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("busy-start latency", 32'(lat), 32'd33);
        chk("busy-start lo", lo, 32'h0000_000E);
        chk("busy-start hi", hi, 32'h0000_0002);
        @(posedge clk); #1;
        chk("busy-start not relaunched", 32'(busy), 32'd0);

        // Abort mid-CALC: no done, HI/LO retained
        op = 3'd1; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
        chk("abort no done", 32'(seen), 32'd0);
        chk("abort hi kept", hi, 32'h0000_0002);
        chk("abort lo kept", lo, 32'h0000_000E);

        // Abort at the FINISH edge beats completion
        op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 32; i++) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("finish-abort done", 32'(done), 32'd0);
        chk("finish-abort busy", 32'(busy), 32'd0);
        chk("finish-abort lo kept", lo, 32'h0000_000E);

        // Abort in IDLE does nothing; then a clean multiply
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle abort busy", 32'(busy), 32'd0);
        run_op(3'd1, 32'd6, 32'd7, lat);
        chk("post-abort latency", 32'(lat), 32'd33);
        chk("post-abort lo", lo, 32'h0000_002A);
        chk("post-abort hi", hi, 32'h0000_0000);

        // Asynchronous reset mid-divide
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        m_hi = 32'd0; m_lo = 32'd0;
        run_and_check("post-reset multu", 3'd1, 32'd3, 32'd4);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            if (o < 3'd4) begin
                run_and_check($sformatf("rand%0d op%0d", i, o), o, x, y);
            end else begin
                model_apply(o, x, y);
                op = o; a = x; b = y; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk($sformatf("rand%0d op%0d hi", i, o), hi, m_hi);
                chk($sformatf("rand%0d op%0d lo", i, o), lo, m_lo);
                chk($sformatf("rand%0d op%0d busy", i, o), 32'(busy), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It executes the mult and div operations that the ALU decoder emits, plus their unsigned forms and mthi/mtlo. It sits beside the single-cycle ALU in the execute stage. The controller launches an operation with a start/busy/done handshake and stalls while busy is high.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; WIDTH >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (low = reset asserted).
start  input  1  request; sampled only in IDLE.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
b  input  WIDTH  rt operand (divisor / multiplier).
abort  input  1  synchronous cancel of an in-flight operation.
busy  output  1  high while in CALC or FINISH.
done  output  1  registered, one-cycle pulse; hi/lo valid in the same cycle.
div_by_zero  output  1  registered; valid with done, cleared on the next accepted start.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset low): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset mid-operation discards all progress.
- FSM states are IDLE, CALC and FINISH. busy = (state != IDLE).
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - At the sampling edge (edge 0), latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Latch the result signs and clear the counter.
  - Go to CALC. Exception: DIV/DIVU with b==0 goes directly to FINISH.
- IDLE, start=1, op=MTHI/MTLO: hi (resp. lo) := a at edge 0. State stays IDLE. No done, no busy.
- IDLE, start=1, op=110/111: no effect.
- CALC:
  - Multiply: one shift-add iteration per cycle.
  - Divide: one restoring shift-subtract iteration per cycle.
  - Exactly WIDTH iterations (edges 1..WIDTH), then FINISH.
- FINISH (one edge):
  - Apply sign correction. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a.
  - Write hi := product[2W-1:W] or remainder; lo := product[W-1:0] or quotient.
  - Pulse done=1 and return to IDLE.
- Latency: done is high in the cycle after edge WIDTH+1 (33 cycles for WIDTH=32). busy falls in that same cycle.
- Divide by zero: done is high after edge 1; hi := a, lo := all-ones, div_by_zero=1.
- Signed DIV of MIN by -1: lo := MIN, hi := 0. No trap, no flag.
- start while busy: ignored. The controller must hold start until it is sampled in IDLE.
- start is accepted in the same cycle done is high, because state is already IDLE.
- abort=1 in CALC or FINISH: return to IDLE at that edge; hi/lo unchanged; no done.
- abort in IDLE: no effect.
- abort has priority over FINISH completion.
- hi/lo change only on FINISH, MTHI/MTLO, or reset.

Decomposition:
- Package muldiv_pkg holds:
  - Op encoding typedef (enum logic [2:0]: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO).
  - State enum (S_IDLE, S_CALC, S_FINISH).
- One natural sub-module, muldiv_step: combinational, WIDTH-parametrised single iteration. Inputs are mode and the partial accumulator/remainder/quotient; outputs are the next values.
- muldiv_unit holds the FSM, counter, sign logic and the HI/LO registers.

Test Plan:
- Run all checks with WIDTH=32.
- MULTU a=FFFFFFFF b=FFFFFFFF -> done exactly 33 cycles after start, busy high cycles 1..32, hi=FFFFFFFE lo=00000001.
- MULT a=-3 b=5, then DIV a=-7 b=2 back-to-back (second start issued in the done cycle) -> first hi=FFFFFFFF lo=FFFFFFF1; second lo=FFFFFFFD hi=FFFFFFFF, done 33 cycles after second start.
- DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000, div_by_zero=0. DIVU a=0000000A b=0 -> done after 1 edge, hi=0000000A lo=FFFFFFFF div_by_zero=1.
- MTHI a=12345678 then MTLO a=9ABCDEF0 -> hi/lo updated the next cycle, busy and done never asserted. Then start DIVU 100/7 and pulse start again at cycle 5 -> second start ignored, result lo=0000000E hi=00000002.
- Start MULTU 6*7, abort at cycle 10 -> busy low from cycle 11, no done, hi/lo retain prior values. Then start MULTU 6*7 -> lo=0000002A hi=0.
- Start DIV 100/7, drive reset low at cycle 15 (asynchronous, between edges) -> busy, done, hi and lo all 0 immediately. After release, a new MULTU completes normally.
